// File: rtl/player_move.sv
// Player sprite controller: joystick-driven grid movement, walk animation, hit/death/respawn FSM.
// Latency: one cycle from the sampling edge; no backpressure, keys and pulses are sampled each clock.
module player_move #(
  parameter int         PLAYER_NUM = 1,
  parameter logic [9:0] START_X    = (PLAYER_NUM == 2) ? 10'd576 : 10'd32,
  parameter logic [9:0] START_Y    = (PLAYER_NUM == 2) ? 10'd416 : 10'd32,
  parameter logic [9:0] X_MIN      = 10'd32,
  parameter logic [9:0] X_MAX      = 10'd576,
  parameter logic [9:0] Y_MIN      = 10'd32,
  parameter logic [9:0] Y_MAX      = 10'd416,
  parameter int         ANIM_DIV   = 8,
  parameter int         HIT_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       hit,
  input  logic       respawn,
  output logic [9:0] playerX,
  output logic [9:0] playerY,
  output logic [2:0] sprite_num,
  output logic [2:0] state,
  output logic [1:0] lives
);

  localparam int AW = (ANIM_DIV < 2) ? 1 : $clog2(ANIM_DIV);
  localparam int HW = (HIT_FRAMES < 8) ? 3 : $clog2(HIT_FRAMES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WALK, S_HIT, S_DEAD} fsm_e;

  fsm_e          fsm_q, fsm_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic [1:0]    dir_q, dir_d;
  logic          walk_q, walk_d;
  logic [AW-1:0] anim_q, anim_d;
  logic [HW-1:0] hit_q, hit_d;
  logic [1:0]    lives_q, lives_d;

  logic          key_any;
  logic [1:0]    key_dir;
  logic [9:0]    x_mv, y_mv;
  logic [AW-1:0] anim_nx;
  logic          walk_nx;
  logic          x_al, y_al;

  // Sprites sit on a 32-pixel grid relative to the lower bound; turns only happen on grid lines.
  assign x_al = (x_q[4:0] == X_MIN[4:0]);
  assign y_al = (y_q[4:0] == Y_MIN[4:0]);

  always_comb begin
    key_any = key_up | key_down | key_left | key_right;
    if (key_up)         key_dir = 2'd1;
    else if (key_down)  key_dir = 2'd0;
    else if (key_left)  key_dir = 2'd2;
    else                key_dir = 2'd3;

    x_mv = x_q;
    y_mv = y_q;
    case (key_dir)
      2'd1: if (x_al && y_q > Y_MIN) y_mv = y_q - 10'd1;
      2'd0: if (x_al && y_q < Y_MAX) y_mv = y_q + 10'd1;
      2'd2: if (y_al && x_q > X_MIN) x_mv = x_q - 10'd1;
      2'd3: if (y_al && x_q < X_MAX) x_mv = x_q + 10'd1;
    endcase

    if (anim_q == AW'(ANIM_DIV - 1)) begin
      anim_nx = '0;
      walk_nx = ~walk_q;
    end else begin
      anim_nx = anim_q + AW'(1);
      walk_nx = walk_q;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    x_d     = x_q;
    y_d     = y_q;
    dir_d   = dir_q;
    walk_d  = walk_q;
    anim_d  = anim_q;
    hit_d   = hit_q;
    lives_d = lives_q;

    unique case (fsm_q)
      S_IDLE, S_WALK: begin
        // A hit wins over a coincident frame tick, so that tick never moves the sprite.
        if (hit) begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) begin
            fsm_d = S_DEAD;
          end else begin
            fsm_d = S_HIT;
            hit_d = HW'(HIT_FRAMES);
          end
        end else if (frame_tick) begin
          if (key_any) begin
            fsm_d  = S_WALK;
            x_d    = x_mv;
            y_d    = y_mv;
            dir_d  = key_dir;
            anim_d = anim_nx;
            walk_d = walk_nx;
          end else begin
            fsm_d  = S_IDLE;
            anim_d = '0;
            walk_d = 1'b0;
          end
        end
      end
      S_HIT: begin
        if (frame_tick) begin
          if (key_any) begin
            x_d    = x_mv;
            y_d    = y_mv;
            dir_d  = key_dir;
            anim_d = anim_nx;
            walk_d = walk_nx;
          end
          hit_d = hit_q - HW'(1);
          if (hit_q <= HW'(1)) begin
            fsm_d  = S_IDLE;
            hit_d  = '0;
            anim_d = '0;
            walk_d = 1'b0;
          end
        end
      end
      S_DEAD: begin
        if (respawn) begin
          fsm_d   = S_IDLE;
          x_d     = START_X;
          y_d     = START_Y;
          dir_d   = 2'd0;
          walk_d  = 1'b0;
          anim_d  = '0;
          hit_d   = '0;
          lives_d = 2'd3;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q   <= S_IDLE;
      x_q     <= START_X;
      y_q     <= START_Y;
      dir_q   <= 2'd0;
      walk_q  <= 1'b0;
      anim_q  <= '0;
      hit_q   <= '0;
      lives_q <= 2'd3;
    end else begin
      fsm_q   <= fsm_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dir_q   <= dir_d;
      walk_q  <= walk_d;
      anim_q  <= anim_d;
      hit_q   <= hit_d;
      lives_q <= lives_d;
    end
  end

  // Invulnerability flashes on counter bit 2, i.e. toggles every four ticks.
  always_comb begin
    state = 3'b000;
    if (fsm_q == S_HIT)       state = hit_q[2] ? 3'b111 : 3'b000;
    else if (fsm_q == S_DEAD) state = 3'b101;
  end

  assign playerX    = x_q;
  assign playerY    = y_q;
  assign sprite_num = {dir_q, walk_q};
  assign lives      = lives_q;

endmodule

// File: tb/tb_player_move.sv
// Bench for player_move: directed scenarios plus random stimulus against a behavioural model.
module tb_player_move;
  localparam int XMIN = 32, XMAX = 576, YMIN = 32, YMAX = 416;
  localparam int ANIM = 8, HITF = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       frame_tick = 1'b0, key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic       hit = 1'b0, respawn = 1'b0;
  logic [9:0] playerX, playerY;
  logic [2:0] sprite_num, state;
  logic [1:0] lives;

  int n_pass = 0, n_chk = 0, n_fail = 0;

  // Behavioural model: plain integers, walk frame derived from ticks walked since last idle.
  int    mx, my, mdir, mwalk, mlives, hit_left;
  string mode;

  player_move #(
    .PLAYER_NUM(1), .START_X(10'd32), .START_Y(10'd32),
    .X_MIN(10'd32), .X_MAX(10'd576), .Y_MIN(10'd32), .Y_MAX(10'd416),
    .ANIM_DIV(ANIM), .HIT_FRAMES(HITF)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .hit(hit), .respawn(respawn),
    .playerX(playerX), .playerY(playerY), .sprite_num(sprite_num), .state(state), .lives(lives)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mx = 32; my = 32; mdir = 0; mwalk = 0; mlives = 3; hit_left = 0; mode = "idle";
  endfunction

  function automatic void model_move(input bit u, input bit d, input bit l);
    int  dx = 0, dy = 0;
    bit  ok;
    if (u)      begin mdir = 1; dy = -1; end
    else if (d) begin mdir = 0; dy = 1;  end
    else if (l) begin mdir = 2; dx = -1; end
    else        begin mdir = 3; dx = 1;  end
    ok = (dy != 0) ? ((mx - XMIN) % 32 == 0) : ((my - YMIN) % 32 == 0);
    if (ok && mx + dx >= XMIN && mx + dx <= XMAX && my + dy >= YMIN && my + dy <= YMAX) begin
      mx += dx;
      my += dy;
    end
  endfunction

  function automatic void model_clock(input bit u, input bit d, input bit l, input bit r,
                                      input bit ft, input bit h, input bit rs);
    bit any = u | d | l | r;
    if (mode == "idle" || mode == "walk") begin
      if (h) begin
        mlives--;
        if (mlives == 0) mode = "dead";
        else begin mode = "hit"; hit_left = HITF; end
      end else if (ft) begin
        if (any) begin mode = "walk"; model_move(u, d, l); mwalk++; end
        else begin mode = "idle"; mwalk = 0; end
      end
    end else if (mode == "hit") begin
      if (ft) begin
        if (any) begin model_move(u, d, l); mwalk++; end
        hit_left--;
        if (hit_left == 0) begin mode = "idle"; mwalk = 0; end
      end
    end else if (rs) begin
      model_reset();
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int exp_state;
    exp_state = (mode == "hit") ? (((hit_left / 4) % 2 == 1) ? 7 : 0) : (mode == "dead") ? 5 : 0;
    chk({tag, ".x"}, playerX, mx);
    chk({tag, ".y"}, playerY, my);
    chk({tag, ".sprite"}, sprite_num, mdir * 2 + (mwalk / ANIM) % 2);
    chk({tag, ".state"}, state, exp_state);
    chk({tag, ".lives"}, lives, mlives);
  endtask

  task automatic step(input string tag, input bit u, input bit d, input bit l, input bit r,
                      input bit ft, input bit h, input bit rs);
    @(negedge clk);
    key_up = u; key_down = d; key_left = l; key_right = r;
    frame_tick = ft; hit = h; respawn = rs;
    @(posedge clk);
    model_clock(u, d, l, r, ft, h, rs);
    #1;
    key_up = 0; key_down = 0; key_left = 0; key_right = 0;
    frame_tick = 0; hit = 0; respawn = 0;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1 reset_n = 1'b0;
    #2;
    check_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Right held four ticks.
    for (int i = 0; i < 4; i++) step("right4", 0, 0, 0, 1, 1, 0, 0);
    chk("right4.x36", playerX, 36);
    chk("right4.dir", sprite_num[2:1], 3);

    // Vertical move blocked off-grid, then at the top bound, then priority up over right.
    do_reset();
    step("to33", 0, 0, 0, 1, 1, 0, 0);
    step("up_offgrid", 1, 0, 0, 0, 1, 0, 0);
    chk("up_offgrid.y", playerY, 32);
    chk("up_offgrid.dir", sprite_num[2:1], 1);
    for (int i = 0; i < 31; i++) step("to64", 0, 0, 0, 1, 1, 0, 0);
    chk("to64.x", playerX, 64);
    step("up_at_min", 1, 0, 0, 0, 1, 0, 0);
    chk("up_at_min.y", playerY, 32);
    step("down1", 0, 1, 0, 0, 1, 0, 0);
    chk("down1.y", playerY, 33);
    step("up_right", 1, 0, 0, 1, 1, 0, 0);
    chk("up_right.x", playerX, 64);
    chk("up_right.y", playerY, 32);

    // Walk animation toggles every eight ticks and clears on idle.
    do_reset();
    for (int i = 1; i <= 24; i++) begin
      step("walk", 0, 0, 0, 1, 1, 0, 0);
      if (i == 7)  chk("walk.t7", sprite_num[0], 0);
      if (i == 8)  chk("walk.t8", sprite_num[0], 1);
      if (i == 15) chk("walk.t15", sprite_num[0], 1);
      if (i == 16) chk("walk.t16", sprite_num[0], 0);
      if (i == 24) chk("walk.t24", sprite_num[0], 1);
    end
    step("release", 0, 0, 0, 0, 1, 0, 0);
    chk("release.sprite", sprite_num, 6);

    // Hits, flashing, ignored re-hit, death and respawn.
    do_reset();
    for (int i = 0; i < 5; i++) step("pre_hit", 0, 0, 0, 1, 1, 0, 0);
    step("hit1", 0, 0, 0, 1, 1, 1, 0);
    chk("hit1.x_held", playerX, 37);
    chk("hit1.lives", lives, 2);
    step("flash1", 0, 0, 0, 0, 1, 0, 0);
    chk("flash1.state", state, 7);
    for (int i = 0; i < 3; i++) step("flash", 0, 0, 0, 0, 1, 0, 0);
    step("flash5", 0, 0, 0, 0, 1, 0, 0);
    chk("flash5.state", state, 0);
    step("rehit", 0, 0, 0, 0, 1, 1, 0);
    chk("rehit.lives", lives, 2);
    for (int i = 0; i < 100 && mode == "hit"; i++) step("hit_run", 0, 0, 0, 0, 1, 0, 0);
    chk("hit_end.state", state, 0);
    step("hit2", 0, 0, 0, 0, 0, 1, 0);
    chk("hit2.lives", lives, 1);
    for (int i = 0; i < 100 && mode == "hit"; i++) step("hit_run2", 0, 0, 0, 0, 1, 0, 0);
    step("hit3", 0, 0, 0, 0, 0, 1, 0);
    chk("hit3.lives", lives, 0);
    chk("hit3.state", state, 5);
    step("dead_key", 0, 0, 0, 1, 1, 0, 0);
    chk("dead_key.x", playerX, 37);
    step("respawn", 0, 0, 0, 0, 0, 0, 1);
    chk("respawn.x", playerX, 32);
    chk("respawn.y", playerY, 32);
    chk("respawn.lives", lives, 3);

    // Asynchronous reset landing mid-HIT between clock edges.
    step("hit4", 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 10; i++) step("hit4_run", 0, 0, 0, 0, 1, 0, 0);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    step("post_rst_hit", 0, 0, 0, 0, 0, 1, 0);

    // Random phase.
    for (int i = 0; i < 3000; i++) begin
      step("rand",
           $urandom_range(0, 9) < 2, $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 4,
           $urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/player_move.md
PLAYER_MOVE -- requirements
Module: player_move

Interface
REQ-001 SHALL have parameter PLAYER_NUM, default 1: player index, used only to select START_X/START_Y defaults at instantiation.
REQ-002 SHALL have parameters START_X/START_Y, default 10'd32/10'd32: spawn position.
REQ-003 SHALL have parameters X_MIN/X_MAX/Y_MIN/Y_MAX, default 32/576/32/416: inclusive sprite top-left bounds.
REQ-004 SHALL have parameter ANIM_DIV, default 8: frame ticks per walk-frame toggle.
REQ-005 SHALL have parameter HIT_FRAMES, default 64: frame ticks of hit invulnerability.
REQ-006 SHALL have port clk, input, 1: single clock; all state changes on rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port frame_tick, input, 1: one-cycle pulse per video frame.
REQ-009 SHALL have ports key_up/key_down/key_left/key_right, input, 1 each: level joystick inputs.
REQ-010 SHALL have port hit, input, 1: one-cycle pulse, player touched by blast.
REQ-011 SHALL have port respawn, input, 1: one-cycle pulse, restart after death.
REQ-012 SHALL have ports playerX/playerY, output, 10 each: sprite top-left, registered.
REQ-013 SHALL have port sprite_num, output, 3: {dir[1:0], walk_frame}; dir 0 down, 1 up, 2 left, 3 right.
REQ-014 SHALL have port state, output, 3: colour-XOR code for the renderer.
REQ-015 SHALL have port lives, output, 2: remaining lives.

Function
REQ-016 SHALL implement FSM states IDLE, WALK, HIT, DEAD; IDLE/WALK SHALL drive state=3'b000.
REQ-017 SHALL sample keys and update position/FSM only on cycles with frame_tick=1; all outputs change on the edge that samples frame_tick (one-cycle latency).
REQ-018 SHALL resolve multiple pressed keys by priority up > down > left > right; the winning key only is considered.
REQ-019 SHALL move exactly 1 pixel per tick in the winning direction (up: Y-1, down: Y+1, left: X-1, right: X+1).
REQ-020 SHALL permit vertical moves only when (playerX-X_MIN)[4:0]==0 and horizontal moves only when (playerY-Y_MIN)[4:0]==0; otherwise the move is ignored, position holds, dir still updates.
REQ-021 SHALL saturate position at bounds: a move that would exceed X_MIN..X_MAX or Y_MIN..Y_MAX leaves the coordinate unchanged; no wrap-around.
REQ-022 SHALL set dir to the winning key's direction on every tick a key is pressed; dir holds when no key is pressed.
REQ-023 SHALL go IDLE->WALK on a tick with any key pressed and WALK->IDLE on a tick with none; HIT state moves per REQ-018..022 without changing to WALK.
REQ-024 SHALL count ticks in WALK/HIT-with-movement and toggle walk_frame every ANIM_DIV ticks; counter and walk_frame clear to 0 on entering IDLE.
REQ-025 SHALL on hit=1 in IDLE or WALK: decrement lives; if result is 0 enter DEAD, else enter HIT and load a HIT_FRAMES tick counter; hit is acted on in the cycle it occurs, independent of frame_tick.
REQ-026 SHALL ignore hit while in HIT or DEAD.
REQ-027 SHALL in HIT drive state=3'b111 when hit counter bit 2 is 1, else 3'b000 (flash every 4 ticks); decrement counter per tick; at 0 return to IDLE.
REQ-028 SHALL in DEAD freeze position and sprite_num, drive state=3'b101, ignore keys.
REQ-029 SHALL on respawn=1 in DEAD return to IDLE with position START_X/START_Y, lives=3, dir=down, walk_frame=0; respawn outside DEAD is ignored.
REQ-030 SHALL, if hit and frame_tick coincide, apply the hit transition and suppress that tick's movement.

Reset
REQ-031 SHALL on reset_n=0 immediately set playerX=START_X, playerY=START_Y, sprite_num=3'b000, state=3'b000, lives=2'd3, FSM=IDLE, all counters 0, regardless of clock or current state.
REQ-032 SHALL resume normal operation on the first rising clk edge after reset_n deasserts; a reset mid-HIT or mid-DEAD SHALL fully clear that status.

Verification
REQ-033 SHALL verify: reset, key_right held 4 ticks -> playerX 32->36, playerY 32, sprite_num dir=3.
REQ-034 SHALL verify: at X=33,Y=32 press key_up -> Y stays 32, sprite_num[2:1]=1; at X=64 key_up at Y=32 (=Y_MIN) -> Y stays 32.
REQ-035 SHALL verify: key_up and key_right together at aligned X -> only Y changes.
REQ-036 SHALL verify: key_right held 16 ticks -> walk_frame toggles at ticks 8 and 16; release -> IDLE, walk_frame=0.
REQ-037 SHALL verify: three hits spaced >64 ticks -> lives 3->2->1->0, state flashes 000/111 during HIT, final state=101; second hit within HIT ignored; respawn -> (32,32), lives=3.
REQ-038 SHALL verify: reset_n pulsed low mid-HIT between clock edges -> outputs reach reset values before next edge.
